// File: rtl/dpu_control_seq.sv
// Microcode sequencer emitting one registered control word per clock to the FRAM unit network.
// Define DPU_SEQ_LOOP_EN to make the program wrap to word 0 instead of returning to IDLE.
module dpu_control_seq #(
  parameter int WS    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [WS-1:0] prog_data,
  input  logic [AW-1:0] prog_len,
  input  logic          start,
  input  logic          stop,
  output logic [WS-1:0] signals_out,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] len_lat;
  logic [WS-1:0] mem [DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] len_clamped;
  logic          addr_ok;

  assign pc_inc      = pc + AW'(1);
  assign len_clamped = ({1'b0, prog_len} >= DEPTH_W) ? LAST_IDX : prog_len;
  assign addr_ok     = ({1'b0, prog_addr} < DEPTH_W);

  // Program memory is never cleared and is frozen while a program executes.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && prog_we && addr_ok)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      signals_out <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len_lat     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            len_lat     <= len_clamped;
            signals_out <= mem[0];
            pc          <= '0;
            busy        <= 1'b1;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          // Stop wins over end-of-program and never pulses done.
          if (stop) begin
            signals_out <= '0;
            pc          <= '0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (pc < len_lat) begin
            signals_out <= mem[pc_inc];
            pc          <= pc_inc;
          end else begin
            done <= 1'b1;
            pc   <= '0;
`ifdef DPU_SEQ_LOOP_EN
            signals_out <= mem[0];
`else
            signals_out <= '0;
            busy        <= 1'b0;
            state       <= S_IDLE;
`endif
          end
        end
      endcase
    end
  end

endmodule
